debug_hex_mux: RTL and testbench

Parametrised debug display multiplexer that selects one of `N_CH` packed probe words and presents it as `DIGITS` hex nibbles for the board's `HexDriver` instances. It replaces the fixed switch-decoded hex case statement in the top level. It adds three capabilities:

- arbitrary channel count and probe width;
- a trigger-armed freeze capture mode;
- a timed auto-cycle mode that rotates through all channels.

It sits between the NES debug taps (CPU registers, bus address, ROM programmer) and the seven-segment drivers.

---
 rtl/debug_hex_mux.sv | 145 ++++++++++++++
 tb/tb_debug_hex_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/debug_hex_mux.sv
// debug_hex_mux: picks one of N_CH probe words and shows it as DIGITS hex
// nibbles. Supports live view, trigger-armed freeze capture, timed
// auto-cycle through all channels, and a hold mode.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_ARMED    | freeze mode follows probe[sel], waiting for a trigger edge
// ST_CAPTURED | freeze mode holds the word captured on the trigger edge
module debug_hex_mux #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 24,
  parameter int DIGITS = 6,
  parameter int DWELL  = 50_000_000,
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W = $clog2(DWELL),
  localparam int HEX_W = 4 * DIGITS
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [N_CH*DATA_W-1:0] probe_data,
  input  logic [CW-1:0]          sel,
  input  logic [1:0]             mode,
  input  logic                   trig,
  input  logic                   arm,
  output logic [HEX_W-1:0]       hex_digits,
  output logic [DIGITS-1:0]      digit_en,
  output logic [CW-1:0]          cur_ch,
  output logic                   captured
);

  localparam logic [1:0] MODE_LIVE   = 2'b00;
  localparam logic [1:0] MODE_FREEZE = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [0:0] ST_ARMED    = 1'b0;
  localparam logic [0:0] ST_CAPTURED = 1'b1;

  logic [HEX_W-1:0] hex_q, hex_d;
  logic [CW-1:0]    cur_ch_q, cur_ch_d;
  logic             captured_q, captured_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q;
  logic [1:0]       mode_q;
  logic             trig_edge;
  logic [HEX_W-1:0] sel_word, cur_word;

  // Out-of-range indices (non power-of-2 N_CH) read as zero.
  function automatic logic [HEX_W-1:0] pick(input logic [CW-1:0] idx,
                                            input logic [N_CH*DATA_W-1:0] probes);
    logic [HEX_W-1:0] w;
    w = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(idx) == k) w[DATA_W-1:0] = probes[k*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  assign trig_edge = trig & ~trig_q;
  assign sel_word  = pick(sel, probe_data);
  assign cur_word  = pick(cur_ch_q, probe_data);

  // Static digit blanking: only nibbles overlapping the probe word are lit.
  for (genvar i = 0; i < DIGITS; i++) begin : g_den
    assign digit_en[i] = (4 * i < DATA_W);
  end

  // Next-state selection for display, channel, dwell counter and freeze FSM.
  always_comb begin
    hex_d      = hex_q;
    cur_ch_d   = cur_ch_q;
    captured_d = captured_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    // Leaving freeze mode always drops back to ARMED.
    if (mode != MODE_FREEZE) begin
      state_d    = ST_ARMED;
      captured_d = 1'b0;
    end
    case (mode)
      MODE_LIVE: begin
        cur_ch_d = sel;
        hex_d    = sel_word;
      end
      MODE_FREEZE: begin
        if (state_q == ST_ARMED) begin
          cur_ch_d = sel;
          hex_d    = sel_word;
          if (trig_edge) begin
            state_d    = ST_CAPTURED;
            captured_d = 1'b1;
          end
        end else if (arm) begin
          // arm beats a simultaneous trigger edge; display held this cycle
          state_d    = ST_ARMED;
          captured_d = 1'b0;
        end
      end
      MODE_AUTO: begin
        hex_d = cur_word;
        if (mode_q != MODE_AUTO) begin
          cur_ch_d = sel;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d    = '0;
          cur_ch_d = (int'(cur_ch_q) >= N_CH - 1) ? '0 : cur_ch_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MODE_HOLD: begin
        hex_d    = hex_q;
        cur_ch_d = cur_ch_q;
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hex_q      <= '0;
      cur_ch_q   <= '0;
      captured_q <= 1'b0;
      state_q    <= ST_ARMED;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      mode_q     <= MODE_LIVE;
    end else begin
      hex_q      <= hex_d;
      cur_ch_q   <= cur_ch_d;
      captured_q <= captured_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig;
      mode_q     <= mode;
    end
  end

  assign hex_digits = hex_q;
  assign cur_ch     = cur_ch_q;
  assign captured   = captured_q;

endmodule

// File: tb/tb_debug_hex_mux.sv
// Directed bench for debug_hex_mux with N_CH=4, DATA_W=12, DIGITS=6, DWELL=4.
module tb_debug_hex_mux;

  localparam int N_CH   = 4;
  localparam int DATA_W = 12;
  localparam int DIGITS = 6;
  localparam int DWELL  = 4;
  localparam int CW     = 2;

  logic                   Clk = 1'b0;
  logic                   Reset_n;
  logic [N_CH*DATA_W-1:0] probe_data;
  logic [CW-1:0]          sel;
  logic [1:0]             mode;
  logic                   trig;
  logic                   arm;
  logic [4*DIGITS-1:0]    hex_digits;
  logic [DIGITS-1:0]      digit_en;
  logic [CW-1:0]          cur_ch;
  logic                   captured;

  int n_vec = 0;
  int n_err = 0;

  debug_hex_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .DIGITS(DIGITS), .DWELL(DWELL)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .probe_data(probe_data), .sel(sel), .mode(mode),
    .trig(trig), .arm(arm), .hex_digits(hex_digits), .digit_en(digit_en),
    .cur_ch(cur_ch), .captured(captured)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    probe_data[k*DATA_W +: DATA_W] = v;
  endtask

  int seq [5] = '{3, 0, 1, 2, 3};

  initial begin
    Reset_n    = 1'b0;
    probe_data = {12'h444, 12'h333, 12'h222, 12'h111};
    sel = 2'd1; mode = 2'b00; trig = 1'b0; arm = 1'b0;
    tick(); tick();
    chk_eq("rst_hex", 32'(hex_digits), 32'h0);
    chk_eq("rst_cur_ch", 32'(cur_ch), 32'h0);
    chk_eq("rst_captured", 32'(captured), 32'h0);
    chk_eq("digit_en_rst", 32'(digit_en), 32'h07);

    // live
    Reset_n = 1'b1; mode = 2'b00; sel = 2'd2; set_ch(2, 12'hABC);
    tick();
    chk_eq("live_hex_abc", 32'(hex_digits), 32'h000ABC);
    chk_eq("live_cur_ch", 32'(cur_ch), 32'h2);
    set_ch(2, 12'h123);
    tick();
    chk_eq("live_hex_123", 32'(hex_digits), 32'h000123);

    // freeze: capture, ignore second edge, re-arm
    mode = 2'b01; sel = 2'd1; set_ch(1, 12'h055);
    tick();
    chk_eq("armed_live", 32'(hex_digits), 32'h000055);
    chk_eq("armed_capt0", 32'(captured), 32'h0);
    trig = 1'b1;
    tick();
    chk_eq("capt_hex", 32'(hex_digits), 32'h000055);
    chk_eq("capt_flag", 32'(captured), 32'h1);
    trig = 1'b0; set_ch(1, 12'hFFF);
    tick();
    chk_eq("capt_hold", 32'(hex_digits), 32'h000055);
    trig = 1'b1;
    tick();
    chk_eq("capt_2nd_trig", 32'(hex_digits), 32'h000055);
    chk_eq("capt_2nd_flag", 32'(captured), 32'h1);
    trig = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    chk_eq("arm_capt0", 32'(captured), 32'h0);
    chk_eq("arm_hex_held", 32'(hex_digits), 32'h000055);
    arm = 1'b0;
    tick();
    chk_eq("rearm_live", 32'(hex_digits), 32'h000FFF);

    // arm and trigger edge together while CAPTURED: arm wins
    trig = 1'b1;
    tick();
    chk_eq("capt2_flag", 32'(captured), 32'h1);
    trig = 1'b0;
    tick();
    set_ch(1, 12'h0AA); arm = 1'b1; trig = 1'b1;
    tick();
    chk_eq("simul_capt0", 32'(captured), 32'h0);
    chk_eq("simul_hex", 32'(hex_digits), 32'h000FFF);
    arm = 1'b0;
    tick();
    chk_eq("simul_live", 32'(hex_digits), 32'h0000AA);
    chk_eq("simul_no_capt", 32'(captured), 32'h0);
    trig = 1'b0;
    tick();
    set_ch(1, 12'h0BB); trig = 1'b1;
    tick();
    chk_eq("iso_capt_flag", 32'(captured), 32'h1);
    chk_eq("iso_capt_hex", 32'(hex_digits), 32'h0000BB);
    trig = 1'b0; set_ch(1, 12'h0CC);
    tick();
    chk_eq("iso_capt_hold", 32'(hex_digits), 32'h0000BB);

    // auto-cycle with wrap
    mode = 2'b00; sel = 2'd3;
    probe_data = {12'h333, 12'h222, 12'h111, 12'h000};
    tick();
    chk_eq("pre_auto_cap0", 32'(captured), 32'h0);
    mode = 2'b10;
    tick();
    chk_eq("auto_e0_ch", 32'(cur_ch), 32'h3);
    for (int j = 1; j < 20; j++) begin
      tick();
      chk_eq($sformatf("auto_ch_%0d", j), 32'(cur_ch), 32'(seq[j/4]));
      chk_eq($sformatf("auto_hex_%0d", j), 32'(hex_digits), 32'(12'h111 * seq[(j-1)/4]));
    end
    tick();
    chk_eq("auto_e20_ch", 32'(cur_ch), 32'h0);
    tick();
    chk_eq("auto_e21_hex", 32'(hex_digits), 32'h000000);

    // hold mid-dwell
    mode = 2'b11; set_ch(0, 12'hFED); sel = 2'd2;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_eq($sformatf("hold_hex_%0d", j), 32'(hex_digits), 32'h000000);
      chk_eq($sformatf("hold_ch_%0d", j), 32'(cur_ch), 32'h0);
      set_ch(0, 12'hFED - 12'(j + 1));
    end

    // reset while CAPTURED
    mode = 2'b01; sel = 2'd2;
    tick();
    trig = 1'b1;
    tick();
    chk_eq("pre_rst_capt", 32'(captured), 32'h1);
    chk_eq("pre_rst_hex", 32'(hex_digits), 32'h000222);
    Reset_n = 1'b0;
    tick();
    chk_eq("mid_rst_hex", 32'(hex_digits), 32'h0);
    chk_eq("mid_rst_ch", 32'(cur_ch), 32'h0);
    chk_eq("mid_rst_capt", 32'(captured), 32'h0);
    Reset_n = 1'b1;
    tick();
    chk_eq("post_rst_edge_capt", 32'(captured), 32'h1);
    chk_eq("post_rst_edge_hex", 32'(hex_digits), 32'h000222);
    chk_eq("digit_en_end", 32'(digit_en), 32'h07);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
